// File: rtl/tcdm_interco_pkg.sv
// Shared helpers for the TCDM interconnect: index-width sizing for the
// per-bank arbiter and its response pipe.
package tcdm_interco_pkg;

    // Width of a master index; a degenerate single master still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of one response-pipe entry {vld, idx}.
    function automatic int resp_ent_w(input int n);
        return idx_w(n) + 1;
    endfunction

endpackage

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Bundle between the masters' side and the bank side of one per-bank
// arbiter; the slave modport is the arbiter's view.
interface tcdm_bank_rr_arbiter_if #(
    parameter int NumMaster     = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32
);
    logic [NumMaster-1:0]                   req_i;
    logic [NumMaster-1:0][ReqDataWidth-1:0] data_i;
    logic [NumMaster-1:0]                   gnt_o;
    logic [NumMaster-1:0]                   rvld_o;
    logic [RespDataWidth-1:0]               rdata_o;
    logic                                   req_o;
    logic                                   gnt_i;
    logic [ReqDataWidth-1:0]                data_o;
    logic [RespDataWidth-1:0]               rdata_i;

    modport slave (
        input  req_i, data_i, gnt_i, rdata_i,
        output gnt_o, rvld_o, rdata_o, req_o, data_o
    );

    modport master (
        output req_i, data_i, gnt_i, rdata_i,
        input  gnt_o, rvld_o, rdata_o, req_o, data_o
    );
endinterface

// File: rtl/tcdm_resp_pipe.sv
// Fixed-depth {vld, idx} shift register that tracks which master owns each
// in-flight bank response; it never stalls because the bank cannot.
module tcdm_resp_pipe #(
    parameter int IdxW  = 2,
    parameter int Depth = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            vld_i,
    input  logic [IdxW-1:0] idx_i,
    output logic            vld_o,
    output logic [IdxW-1:0] idx_o
);
    typedef struct packed {
        logic            vld;
        logic [IdxW-1:0] idx;
    } resp_ent_t;

    resp_ent_t [Depth-1:0] vld_pipe;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0].vld <= vld_i;
            vld_pipe[0].idx <= idx_i;
            for (int s = 1; s < Depth; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
            end
        end
    end

    assign vld_o = vld_pipe[Depth-1].vld;
    assign idx_o = vld_pipe[Depth-1].idx;
endmodule

// File: rtl/tcdm_bank_rr_arbiter.sv
// Per-bank round-robin arbiter: combinational grant, response routed back
// through a RespLat-deep owner pipe. TCDM_ARB_PERF_CNT_EN adds a conflict counter.
module tcdm_bank_rr_arbiter
    import tcdm_interco_pkg::*;
#(
    parameter int NumMaster     = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int RespLat       = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    tcdm_bank_rr_arbiter_if.slave      bus
`ifdef TCDM_ARB_PERF_CNT_EN
    ,
    input  logic                       cnt_clr_i,
    output logic [31:0]                conflict_cnt_o
`endif
);
    localparam int IdxW = idx_w(NumMaster);

    logic [IdxW-1:0] rr_q;
    logic [IdxW-1:0] winner;
    logic            hs;
    logic            pipe_vld;
    logic [IdxW-1:0] pipe_idx;

    // Scan offsets high to low so the smallest offset from rr_q wins.
    always_comb begin
        int c;
        winner = '0;
        for (int k = NumMaster - 1; k >= 0; k--) begin
            c = int'(rr_q) + k;
            if (c >= NumMaster) c = c - NumMaster;
            if (bus.req_i[IdxW'(c)]) winner = IdxW'(c);
        end
    end

    assign bus.req_o   = |bus.req_i;
    assign bus.data_o  = bus.data_i[winner];
    assign hs          = bus.req_o & bus.gnt_i;
    assign bus.rdata_o = bus.rdata_i;

    for (genvar m = 0; m < NumMaster; m++) begin : g_lane
        assign bus.gnt_o[m]  = hs && (winner == IdxW'(m));
        assign bus.rvld_o[m] = pipe_vld && (pipe_idx == IdxW'(m));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (hs) begin
            rr_q <= (winner == IdxW'(NumMaster - 1)) ? '0 : winner + 1'b1;
        end
    end

    tcdm_resp_pipe #(
        .IdxW  (IdxW),
        .Depth (RespLat)
    ) i_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (hs),
        .idx_i  (winner),
        .vld_o  (pipe_vld),
        .idx_o  (pipe_idx)
    );

`ifdef TCDM_ARB_PERF_CNT_EN
    logic [31:0] cnt_q;
    logic        conflict;

    assign conflict = $countones(bus.req_i) >= 2;

    // Clear has priority; the counter sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (conflict && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = cnt_q;
`else
    // Without the counter the request set only drives arbitration.
`endif
endmodule
